// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - conditional branch resolver with 2-bit BHT predictor
//
// Resolves EX-stage conditional branches one cycle after acceptance and
// predicts fetch PCs from a table of 2-bit saturating counters.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   if_pc, pred_taken   fetch PC and its combinational prediction
//   ex_valid, ex_kill   EX instruction valid / squash
//   ex_opcode/funct3    instruction opcode and branch condition select
//   ex_rs1, ex_rs2      compare operands
//   ex_pc, ex_imm       branch PC and B-type offset (bit 0 ignored)
//   ex_pred_taken       prediction that travelled with the instruction
//   res_valid/res_taken/mispredict/redirect_pc/illegal_br  registered result
//   stat_branches, stat_mispredicts  event counters
//
// Optional feature: define BRANCH_UNIT_STATS_EN to build the event counters;
// otherwise the stat ports are tied to 0.

module branch_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic            ex_kill,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [12:0]     ex_imm,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal_br,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int         IDX_W     = $clog2(BHT_DEPTH);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]      bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;

    logic            accept;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            taken_c;
    logic            illegal_c;
    logic            mis_c;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;

    // PC bits outside the table index and imm bit 0 carry no information here.
    logic unused_bits;
    assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_imm[0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Read is the stored value only: a same-cycle update to this index is
    // not forwarded, so the prediction reflects the pre-update counter.
    assign pred_taken = bht[if_idx][1];

    assign accept = ex_valid && !ex_kill && (ex_opcode == OP_BRANCH);

    assign eq   = (ex_rs1 == ex_rs2);
    assign lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
    assign lt_u = (ex_rs1 < ex_rs2);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (ex_funct3)
            3'b000:  taken_c = eq;
            3'b001:  taken_c = !eq;
            3'b100:  taken_c = lt_s;
            3'b101:  taken_c = !lt_s;
            3'b110:  taken_c = lt_u;
            3'b111:  taken_c = !lt_u;
            default: illegal_c = 1'b1;   // 010 / 011: never taken
        endcase
    end

    assign mis_c   = (taken_c != ex_pred_taken);
    assign imm_ext = {{(XLEN-12){ex_imm[12]}}, ex_imm[11:1], 1'b0};
    assign target  = ex_pc + imm_ext;
    assign seq_pc  = ex_pc + {{(XLEN-3){1'b0}}, 3'd4};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            mispredict  <= 1'b0;
            illegal_br  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            res_valid  <= accept;
            mispredict <= accept && mis_c;
            illegal_br <= accept && illegal_c;
            if (accept) begin
                res_taken   <= taken_c;
                redirect_pc <= taken_c ? target : seq_pc;
                if (!illegal_c) begin
                    if (taken_c && (bht[ex_idx] != 2'b11)) begin
                        bht[ex_idx] <= bht[ex_idx] + 2'b01;
                    end else if (!taken_c && (bht[ex_idx] != 2'b00)) begin
                        bht[ex_idx] <= bht[ex_idx] - 2'b01;
                    end
                end
            end
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (accept) begin
            stat_branches <= stat_branches + 32'd1;
            if (mis_c) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - self-checking bench for branch_unit
`timescale 1ns/1ps

module tb_branch_unit;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    typedef struct {
        logic        vld;
        logic        tk;
        logic        mis;
        logic [31:0] rpc;
        logic        ill;
    } out_t;

    typedef struct {
        logic        v;
        logic        k;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [12:0] imm;
        logic        pr;
        out_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid, ex_kill;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc;
    logic [12:0] ex_imm;
    logic        ex_pred_taken;
    logic        res_valid, res_taken, mispredict, illegal_br;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches, stat_mispredicts;

    int n_cmp = 0;
    int n_bad = 0;
    int m_br  = 0;
    int m_mis = 0;
    out_t sbq[$];
    vec_t tbl[15];
    logic [1:0] cnt;

    branch_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_kill(ex_kill), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .illegal_br(illegal_br),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(logic vld, logic tk, logic mis, logic [31:0] rpc, logic ill);
        out_t o;
        o.vld = vld; o.tk = tk; o.mis = mis; o.rpc = rpc; o.ill = ill;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One transaction: drive at negedge, push expectation, compare after edge.
    task automatic step(input string nm, input logic r, input logic v, input logic k,
                        input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [12:0] imm, input logic pr,
                        input out_t e, input logic chk_pred, input logic exp_pred);
        out_t x;
        @(negedge clk);
        rst = r; ex_valid = v; ex_kill = k; ex_opcode = op; ex_funct3 = f3;
        ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm; ex_pred_taken = pr;
        if_pc = pc;
        sbq.push_back(e);
        #1;
        if (chk_pred) chk({nm, ".pred"}, {31'd0, pred_taken}, {31'd0, exp_pred});
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk({nm, ".res_valid"},   {31'd0, res_valid},  {31'd0, x.vld});
        chk({nm, ".res_taken"},   {31'd0, res_taken},  {31'd0, x.tk});
        chk({nm, ".mispredict"},  {31'd0, mispredict}, {31'd0, x.mis});
        chk({nm, ".illegal_br"},  {31'd0, illegal_br}, {31'd0, x.ill});
        chk({nm, ".redirect_pc"}, redirect_pc, x.rpc);
        if (r) begin
            m_br = 0; m_mis = 0;
        end else if (x.vld) begin
            m_br++;
            if (x.mis) m_mis++;
        end
        rst = 1'b0; ex_valid = 1'b0; ex_kill = 1'b0;
    endtask

    task automatic chk_stats(input string nm);
`ifdef BRANCH_UNIT_STATS_EN
        chk({nm, ".stat_branches"},    stat_branches,    m_br);
        chk({nm, ".stat_mispredicts"}, stat_mispredicts, m_mis);
`else
        chk({nm, ".stat_branches"},    stat_branches,    32'd0);
        chk({nm, ".stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
    endtask

    task automatic scan_pred_zero(input string nm);
        for (int i = 0; i < 64; i++) begin
            if_pc = i * 4;
            #0.1;
            chk($sformatf("%s.pred_idx%0d", nm, i), {31'd0, pred_taken}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; ex_valid = 1'b0; ex_kill = 1'b0; ex_opcode = '0; ex_funct3 = '0;
        ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0; ex_pred_taken = 1'b0;
        if_pc = '0;

        //          v  k  op      f3      rs1           rs2           pc            imm      pr  expected
        tbl[0]  = '{1, 0, OP_BR,  3'b000, 32'd5,        32'd5,        32'h100,      13'h010, 0, mk(1,1,1,32'h110,0)};
        tbl[1]  = '{1, 0, OP_BR,  3'b001, 32'd5,        32'd5,        32'h200,      13'h020, 0, mk(1,0,0,32'h204,0)};
        tbl[2]  = '{1, 0, OP_BR,  3'b100, 32'hFFFFFFFF, 32'd1,        32'h300,      13'h1FF0,1, mk(1,1,0,32'h2F0,0)};
        tbl[3]  = '{1, 0, OP_BR,  3'b110, 32'hFFFFFFFF, 32'd1,        32'h300,      13'h1FF0,1, mk(1,0,1,32'h304,0)};
        tbl[4]  = '{1, 0, OP_BR,  3'b101, 32'd1,        32'hFFFFFFFF, 32'h400,      13'h008, 0, mk(1,1,1,32'h408,0)};
        tbl[5]  = '{1, 0, OP_BR,  3'b111, 32'd1,        32'hFFFFFFFF, 32'h400,      13'h008, 0, mk(1,0,0,32'h404,0)};
        tbl[6]  = '{1, 0, OP_BR,  3'b000, 32'd0,        32'd0,        32'hFFFFFFFC, 13'h008, 1, mk(1,1,0,32'h4,0)};
        tbl[7]  = '{1, 0, OP_BR,  3'b000, 32'd3,        32'd3,        32'h500,      13'h011, 1, mk(1,1,0,32'h510,0)};
        tbl[8]  = '{1, 0, OP_BR,  3'b010, 32'd3,        32'd3,        32'h600,      13'h010, 1, mk(1,0,1,32'h604,1)};
        tbl[9]  = '{1, 0, OP_BR,  3'b011, 32'd3,        32'd4,        32'h600,      13'h010, 0, mk(1,0,0,32'h604,1)};
        tbl[10] = '{1, 0, OP_ALU, 3'b000, 32'd1,        32'd1,        32'h700,      13'h010, 0, mk(0,0,0,32'h604,0)};
        tbl[11] = '{1, 1, OP_BR,  3'b000, 32'd1,        32'd1,        32'h700,      13'h010, 0, mk(0,0,0,32'h604,0)};
        tbl[12] = '{0, 0, OP_BR,  3'b000, 32'd1,        32'd1,        32'h700,      13'h010, 0, mk(0,0,0,32'h604,0)};
        tbl[13] = '{1, 0, OP_BR,  3'b101, 32'd7,        32'd7,        32'h800,      13'h1000,1, mk(1,1,0,32'hFFFFF800,0)};
        tbl[14] = '{0, 0, OP_BR,  3'b001, 32'd7,        32'd7,        32'h900,      13'h010, 0, mk(0,1,0,32'hFFFFF800,0)};

        step("reset0", 1, 0, 0, OP_BR, 3'b000, 0, 0, 0, 13'h0, 0, mk(0,0,0,0,0), 0, 0);
        chk_stats("reset0");
        scan_pred_zero("reset0");

        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), 0, tbl[i].v, tbl[i].k, tbl[i].op, tbl[i].f3,
                 tbl[i].a, tbl[i].b, tbl[i].pc, tbl[i].imm, tbl[i].pr, tbl[i].e, 0, 0);
        end
        chk_stats("table");

        // Clean table, then walk one counter through its saturating states.
        step("reset1", 1, 0, 0, OP_BR, 3'b000, 0, 0, 0, 13'h0, 0, mk(0,0,0,0,0), 0, 0);
        scan_pred_zero("reset1");
        cnt = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("sat_t%0d", i), 0, 1, 0, OP_BR, 3'b000, 9, 9, 32'h104, 13'h020,
                 cnt[1], mk(1,1,!cnt[1],32'h124,0), 1, cnt[1]);
            if (cnt != 2'b11) cnt = cnt + 2'b01;
        end
        step("nt1", 0, 1, 0, OP_BR, 3'b000, 9, 8, 32'h104, 13'h020, 1,
             mk(1,0,1,32'h108,0), 1, 1);
        step("ill_keep", 0, 1, 0, OP_BR, 3'b010, 9, 9, 32'h104, 13'h020, 1,
             mk(1,0,1,32'h108,1), 1, 1);
        step("nt2", 0, 1, 0, OP_BR, 3'b000, 9, 8, 32'h104, 13'h020, 1,
             mk(1,0,1,32'h108,0), 1, 1);
        step("kill", 0, 1, 1, OP_BR, 3'b000, 9, 9, 32'h104, 13'h020, 0,
             mk(0,0,0,32'h108,0), 1, 0);
        step("nonbr", 0, 1, 0, OP_ALU, 3'b000, 9, 9, 32'h104, 13'h020, 0,
             mk(0,0,0,32'h108,0), 1, 0);
        step("pre_rst", 0, 1, 0, OP_BR, 3'b000, 1, 1, 32'h108, 13'h020, 0,
             mk(1,1,1,32'h128,0), 1, 0);
        chk_stats("seq");

        // Reset wins over an accepted taken branch at a weakly-taken index.
        step("rst_br", 1, 1, 0, OP_BR, 3'b000, 1, 1, 32'h108, 13'h020, 1,
             mk(0,0,0,0,0), 1, 1);
        chk_stats("rst_br");
        scan_pred_zero("rst_br");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
